// File: rtl/cosim_commit_sched_if.sv
// Retirement-side and checker-side signal bundle for the commit-event scheduler.
// The slave modport is the scheduler's view; the master modport is the
// environment that drives retirements and consumes events.
interface cosim_commit_sched_if #(
    parameter int COMMITS = 2,
    parameter int XLEN    = 64
);
    logic [COMMITS-1:0]      commit_valid;
    logic [COMMITS*XLEN-1:0] commit_pc;
    logic [COMMITS*32-1:0]   commit_insn;
    logic [COMMITS-1:0]      commit_wen;
    logic [COMMITS*5-1:0]    commit_waddr;
    logic [COMMITS*XLEN-1:0] commit_wdata;
    logic                    trap_valid;
    logic [XLEN-1:0]         trap_cause;

    logic                    ev_valid;
    logic                    ev_ready;
    logic                    ev_is_trap;
    logic [XLEN-1:0]         ev_pc;
    logic [31:0]             ev_insn;
    logic                    ev_wen;
    logic [4:0]              ev_waddr;
    logic [XLEN-1:0]         ev_wdata;
    logic [XLEN-1:0]         ev_cause;

    modport master (
        output commit_valid, commit_pc, commit_insn, commit_wen, commit_waddr,
               commit_wdata, trap_valid, trap_cause, ev_ready,
        input  ev_valid, ev_is_trap, ev_pc, ev_insn, ev_wen, ev_waddr,
               ev_wdata, ev_cause
    );

    modport slave (
        input  commit_valid, commit_pc, commit_insn, commit_wen, commit_waddr,
               commit_wdata, trap_valid, trap_cause, ev_ready,
        output ev_valid, ev_is_trap, ev_pc, ev_insn, ev_wen, ev_waddr,
               ev_wdata, ev_cause
    );
endinterface

// File: rtl/cosim_commit_sched.sv
// Commit-event scheduler: merges up to COMMITS retirements plus one trap per
// cycle into an ordered FIFO, streams them one per cycle to the cosim checker,
// throttles the core near full, and sequences halt (checker mismatch) or
// drain (tohost finish).
module cosim_commit_sched #(
    parameter int COMMITS = 2,
    parameter int DEPTH   = 8,
    parameter int XLEN    = 64
) (
    input  logic                     clock,
    input  logic                     reset_n,
    cosim_commit_sched_if.slave      bus,
    input  logic                     finish_req,
    input  logic                     chk_fail,
    output logic                     core_stall,
    output logic                     done,
    output logic                     fail,
    output logic                     overflow,
    output logic                     protocol_err,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W     = $clog2(DEPTH);
    localparam int CNT_W     = PTR_W + 1;
    localparam int NPUSH     = COMMITS + 1;
    localparam int STALL_TH  = DEPTH - (COMMITS + 1);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_HALT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    typedef struct packed {
        logic            is_trap;
        logic [XLEN-1:0] pc;
        logic [31:0]     insn;
        logic            wen;
        logic [4:0]      waddr;
        logic [XLEN-1:0] wdata;
        logic [XLEN-1:0] cause;
    } entry_t;

    state_t            state_r;
    state_t            state_next_s;
    entry_t            mem_r [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [CNT_W-1:0]  count_r;
    logic              fail_r;
    logic              overflow_r;
    logic              protocol_err_r;

    logic              enq_allow_s;
    logic              ev_valid_s;
    logic              core_stall_s;
    logic              done_s;
    logic              pop_s;
    logic [CNT_W-1:0]  free_s;
    logic [CNT_W-1:0]  acc_s;
    logic [CNT_W-1:0]  req_s;
    logic [NPUSH-1:0]  cand_valid_s;
    entry_t            cand_data_s [NPUSH];
    logic [NPUSH-1:0]  push_en_s;
    logic [PTR_W-1:0]  push_idx_s [NPUSH];
    logic              proto_hit_s;
    entry_t            head_s;

    // State register: reset always lands in RUN.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_r <= ST_RUN;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic: mismatch beats finish; HALT and DONE are terminal.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_RUN: begin
                if (chk_fail) begin
                    state_next_s = ST_HALT;
                end else if (finish_req) begin
                    state_next_s = ST_DRAIN;
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (chk_fail) begin
                    state_next_s = ST_HALT;
                end else if ((count_r == {CNT_W{1'b0}}) && (acc_s == {CNT_W{1'b0}})) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_DRAIN;
                end
            end
            ST_HALT:  state_next_s = ST_HALT;
            ST_DONE:  state_next_s = ST_DONE;
            default:  state_next_s = ST_HALT;
        endcase
    end

    // State-decoded controls; stall depends on registered occupancy only.
    always_comb begin
        enq_allow_s  = 1'b0;
        ev_valid_s   = 1'b0;
        done_s       = 1'b0;
        core_stall_s = 1'b1;
        case (state_r)
            ST_RUN: begin
                enq_allow_s  = 1'b1;
                ev_valid_s   = (count_r != {CNT_W{1'b0}});
                core_stall_s = (count_r > CNT_W'(STALL_TH));
            end
            ST_DRAIN: begin
                enq_allow_s  = 1'b1;
                ev_valid_s   = (count_r != {CNT_W{1'b0}});
                core_stall_s = 1'b1;
            end
            ST_HALT: begin
                core_stall_s = 1'b1;
            end
            ST_DONE: begin
                done_s       = 1'b1;
                core_stall_s = 1'b1;
            end
            default: begin
                core_stall_s = 1'b1;
            end
        endcase
    end

    // Build the ordered push candidates: commit slots first, then the trap.
    always_comb begin
        for (int i = 0; i < COMMITS; i++) begin
            cand_valid_s[i]         = enq_allow_s & bus.commit_valid[i];
            cand_data_s[i].is_trap  = 1'b0;
            cand_data_s[i].pc       = bus.commit_pc[i*XLEN +: XLEN];
            cand_data_s[i].insn     = bus.commit_insn[i*32 +: 32];
            cand_data_s[i].wen      = bus.commit_wen[i];
            cand_data_s[i].waddr    = bus.commit_waddr[i*5 +: 5];
            cand_data_s[i].wdata    = bus.commit_wdata[i*XLEN +: XLEN];
            cand_data_s[i].cause    = {XLEN{1'b0}};
        end
        cand_valid_s[COMMITS]        = enq_allow_s & bus.trap_valid;
        cand_data_s[COMMITS].is_trap = 1'b1;
        cand_data_s[COMMITS].pc      = {XLEN{1'b0}};
        cand_data_s[COMMITS].insn    = 32'h0000_0000;
        cand_data_s[COMMITS].wen     = 1'b0;
        cand_data_s[COMMITS].waddr   = 5'd0;
        cand_data_s[COMMITS].wdata   = {XLEN{1'b0}};
        cand_data_s[COMMITS].cause   = bus.trap_cause;
    end

    // A higher slot retiring while a lower one is idle breaks slot contiguity.
    always_comb begin
        proto_hit_s = 1'b0;
        for (int i = 1; i < COMMITS; i++) begin
            if (enq_allow_s && bus.commit_valid[i] && !bus.commit_valid[i-1]) begin
                proto_hit_s = 1'b1;
            end else begin
                proto_hit_s = proto_hit_s;
            end
        end
    end

    // Space accounting: a same-cycle pop frees a slot for this cycle's pushes.
    always_comb begin
        pop_s  = ev_valid_s & bus.ev_ready;
        free_s = CNT_W'(DEPTH) - count_r + CNT_W'(pop_s);
    end

    // Allocate FIFO slots in candidate order; excess (highest-order) pushes drop.
    always_comb begin
        acc_s = {CNT_W{1'b0}};
        req_s = {CNT_W{1'b0}};
        for (int j = 0; j < NPUSH; j++) begin
            push_en_s[j]  = 1'b0;
            push_idx_s[j] = wr_ptr_r + acc_s[PTR_W-1:0];
            if (cand_valid_s[j]) begin
                req_s = req_s + CNT_W'(1);
                if (acc_s < free_s) begin
                    push_en_s[j] = 1'b1;
                    acc_s        = acc_s + CNT_W'(1);
                end else begin
                    push_en_s[j] = 1'b0;
                end
            end else begin
                push_en_s[j] = 1'b0;
            end
        end
    end

    // FIFO storage write; payload needs no reset because outputs are gated.
    always_ff @(posedge clock) begin
        for (int j = 0; j < NPUSH; j++) begin
            if (push_en_s[j]) begin
                mem_r[push_idx_s[j]] <= cand_data_s[j];
            end
        end
    end

    // Pointers, occupancy and sticky error flags.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            wr_ptr_r       <= {PTR_W{1'b0}};
            rd_ptr_r       <= {PTR_W{1'b0}};
            count_r        <= {CNT_W{1'b0}};
            fail_r         <= 1'b0;
            overflow_r     <= 1'b0;
            protocol_err_r <= 1'b0;
        end else begin
            wr_ptr_r       <= wr_ptr_r + acc_s[PTR_W-1:0];
            rd_ptr_r       <= rd_ptr_r + PTR_W'(pop_s);
            count_r        <= count_r + acc_s - CNT_W'(pop_s);
            fail_r         <= fail_r | (state_next_s == ST_HALT);
            overflow_r     <= overflow_r | (req_s != acc_s);
            protocol_err_r <= protocol_err_r | proto_hit_s;
        end
    end

    // Event port from the FIFO head, forced to zero whenever nothing is offered.
    always_comb begin
        head_s         = mem_r[rd_ptr_r];
        bus.ev_valid   = ev_valid_s;
        bus.ev_is_trap = 1'b0;
        bus.ev_pc      = {XLEN{1'b0}};
        bus.ev_insn    = 32'h0000_0000;
        bus.ev_wen     = 1'b0;
        bus.ev_waddr   = 5'd0;
        bus.ev_wdata   = {XLEN{1'b0}};
        bus.ev_cause   = {XLEN{1'b0}};
        if (ev_valid_s) begin
            bus.ev_is_trap = head_s.is_trap;
            bus.ev_pc      = head_s.pc;
            bus.ev_insn    = head_s.insn;
            bus.ev_wen     = head_s.wen;
            bus.ev_waddr   = head_s.waddr;
            bus.ev_wdata   = head_s.wdata;
            bus.ev_cause   = head_s.cause;
        end else begin
            bus.ev_is_trap = 1'b0;
        end
    end

    // Status outputs, all derived from registered state.
    always_comb begin
        core_stall   = core_stall_s;
        done         = done_s;
        fail         = fail_r;
        overflow     = overflow_r;
        protocol_err = protocol_err_r;
        count        = count_r;
    end

endmodule

// File: tb/tb_cosim_commit_sched.sv
// Directed bench for cosim_commit_sched: one task per scenario, inline checks.
module tb_cosim_commit_sched;
    localparam int COMMITS = 2;
    localparam int DEPTH   = 8;
    localparam int XLEN    = 64;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       finish_req;
    logic       chk_fail;
    logic       core_stall;
    logic       done;
    logic       fail;
    logic       overflow;
    logic       protocol_err;
    logic [3:0] count;

    int n_cmp = 0;
    int n_err = 0;

    cosim_commit_sched_if #(.COMMITS(COMMITS), .XLEN(XLEN)) bus ();

    cosim_commit_sched #(.COMMITS(COMMITS), .DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .bus          (bus),
        .finish_req   (finish_req),
        .chk_fail     (chk_fail),
        .core_stall   (core_stall),
        .done         (done),
        .fail         (fail),
        .overflow     (overflow),
        .protocol_err (protocol_err),
        .count        (count)
    );

    always #5 clock = ~clock;

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic clear_core;
        bus.commit_valid = 2'b00;
        bus.commit_pc    = 128'd0;
        bus.commit_insn  = 64'd0;
        bus.commit_wen   = 2'b00;
        bus.commit_waddr = 10'd0;
        bus.commit_wdata = 128'd0;
        bus.trap_valid   = 1'b0;
        bus.trap_cause   = 64'd0;
    endtask

    task automatic clear_inputs;
        clear_core();
        bus.ev_ready = 1'b0;
        finish_req   = 1'b0;
        chk_fail     = 1'b0;
    endtask

    task automatic do_reset;
        clear_inputs();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
    endtask

    task automatic set_slot(input int s, input logic [63:0] pc, input logic [31:0] insn,
                            input logic wen, input logic [4:0] waddr, input logic [63:0] wdata);
        bus.commit_valid[s]            = 1'b1;
        bus.commit_pc[s*XLEN +: XLEN]  = pc;
        bus.commit_insn[s*32 +: 32]    = insn;
        bus.commit_wen[s]              = wen;
        bus.commit_waddr[s*5 +: 5]     = waddr;
        bus.commit_wdata[s*XLEN +: XLEN] = wdata;
    endtask

    task automatic test_reset;
        clear_inputs();
        bus.commit_valid = 2'b11;
        reset_n = 1'b0;
        repeat (3) tick();
        n_cmp++; if (count !== 4'd0) begin n_err++; $display("FAIL reset_count: got %0d expected 0", count); end
        n_cmp++; if (bus.ev_valid !== 1'b0) begin n_err++; $display("FAIL reset_ev_valid: got %b expected 0", bus.ev_valid); end
        n_cmp++; if (bus.ev_pc !== 64'd0) begin n_err++; $display("FAIL reset_ev_pc: got %h expected 0", bus.ev_pc); end
        n_cmp++; if ({core_stall, done, fail, overflow, protocol_err} !== 5'b00000) begin n_err++; $display("FAIL reset_flags: got %b expected 00000", {core_stall, done, fail, overflow, protocol_err}); end
        bus.commit_valid = 2'b00;
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_dual_commit_trap;
        do_reset();
        bus.ev_ready = 1'b1;
        set_slot(0, 64'h0000_0000_8000_0000, 32'h0000_0093, 1'b1, 5'd5, 64'h1234);
        set_slot(1, 64'h0000_0000_8000_0004, 32'h0010_0113, 1'b0, 5'd0, 64'h0);
        bus.trap_valid = 1'b1;
        bus.trap_cause = 64'h2;
        n_cmp++; if (bus.ev_valid !== 1'b0) begin n_err++; $display("FAIL dual_latency: got ev_valid %b expected 0", bus.ev_valid); end
        tick();
        clear_core();
        n_cmp++; if (count !== 4'd3) begin n_err++; $display("FAIL dual_count: got %0d expected 3", count); end
        n_cmp++; if (bus.ev_valid !== 1'b1 || bus.ev_is_trap !== 1'b0 || bus.ev_pc !== 64'h8000_0000) begin n_err++; $display("FAIL dual_ev0: got v=%b t=%b pc=%h expected v=1 t=0 pc=80000000", bus.ev_valid, bus.ev_is_trap, bus.ev_pc); end
        n_cmp++; if (bus.ev_wen !== 1'b1 || bus.ev_waddr !== 5'd5 || bus.ev_wdata !== 64'h1234 || bus.ev_insn !== 32'h0000_0093 || bus.ev_cause !== 64'd0) begin n_err++; $display("FAIL dual_ev0_fields: got wen=%b wa=%0d wd=%h insn=%h cause=%h", bus.ev_wen, bus.ev_waddr, bus.ev_wdata, bus.ev_insn, bus.ev_cause); end
        tick();
        n_cmp++; if (bus.ev_valid !== 1'b1 || bus.ev_pc !== 64'h8000_0004 || bus.ev_insn !== 32'h0010_0113 || bus.ev_wen !== 1'b0) begin n_err++; $display("FAIL dual_ev1: got v=%b pc=%h insn=%h wen=%b expected v=1 pc=80000004 insn=00100113 wen=0", bus.ev_valid, bus.ev_pc, bus.ev_insn, bus.ev_wen); end
        tick();
        n_cmp++; if (bus.ev_valid !== 1'b1 || bus.ev_is_trap !== 1'b1 || bus.ev_cause !== 64'h2 || bus.ev_pc !== 64'd0) begin n_err++; $display("FAIL dual_trap: got v=%b t=%b cause=%h pc=%h expected v=1 t=1 cause=2 pc=0", bus.ev_valid, bus.ev_is_trap, bus.ev_cause, bus.ev_pc); end
        tick();
        n_cmp++; if (bus.ev_valid !== 1'b0 || count !== 4'd0) begin n_err++; $display("FAIL dual_empty: got v=%b count=%0d expected v=0 count=0", bus.ev_valid, count); end
        n_cmp++; if (protocol_err !== 1'b0 || overflow !== 1'b0) begin n_err++; $display("FAIL dual_flags: got perr=%b ovf=%b expected 0 0", protocol_err, overflow); end
    endtask

    task automatic test_backpressure;
        logic [63:0] exp_pc [8];
        logic        exp_stall;
        do_reset();
        for (int k = 1; k <= 6; k++) begin
            clear_core();
            set_slot(0, 64'(k * 4), 32'h13, 1'b0, 5'd0, 64'd0);
            tick();
            exp_stall = (k >= 6);
            n_cmp++; if (count !== 4'(k) || core_stall !== exp_stall) begin n_err++; $display("FAIL bp_fill_%0d: got count=%0d stall=%b expected count=%0d stall=%b", k, count, core_stall, k, exp_stall); end
        end
        clear_core();
        set_slot(0, 64'd28, 32'h13, 1'b0, 5'd0, 64'd0);
        tick();
        n_cmp++; if (count !== 4'd7 || overflow !== 1'b0) begin n_err++; $display("FAIL bp_seven: got count=%0d ovf=%b expected 7 0", count, overflow); end
        clear_core();
        set_slot(0, 64'd32, 32'h13, 1'b0, 5'd0, 64'd0);
        set_slot(1, 64'hdead, 32'h13, 1'b0, 5'd0, 64'd0);
        tick();
        clear_core();
        n_cmp++; if (count !== 4'd8 || overflow !== 1'b1 || core_stall !== 1'b1) begin n_err++; $display("FAIL bp_overflow: got count=%0d ovf=%b stall=%b expected 8 1 1", count, overflow, core_stall); end
        n_cmp++; if (bus.ev_pc !== 64'd4) begin n_err++; $display("FAIL bp_head: got %h expected 4", bus.ev_pc); end
        bus.ev_ready = 1'b1;
        set_slot(0, 64'h100, 32'h13, 1'b0, 5'd0, 64'd0);
        tick();
        clear_core();
        n_cmp++; if (count !== 4'd8 || bus.ev_pc !== 64'd8) begin n_err++; $display("FAIL bp_full_pop_push: got count=%0d pc=%h expected 8 8", count, bus.ev_pc); end
        exp_pc = '{64'd8, 64'd12, 64'd16, 64'd20, 64'd24, 64'd28, 64'd32, 64'h100};
        for (int i = 0; i < 8; i++) begin
            n_cmp++; if (bus.ev_valid !== 1'b1 || bus.ev_pc !== exp_pc[i]) begin n_err++; $display("FAIL bp_drain_%0d: got v=%b pc=%h expected v=1 pc=%h", i, bus.ev_valid, bus.ev_pc, exp_pc[i]); end
            tick();
        end
        n_cmp++; if (count !== 4'd0 || bus.ev_valid !== 1'b0 || core_stall !== 1'b0) begin n_err++; $display("FAIL bp_end: got count=%0d v=%b stall=%b expected 0 0 0", count, bus.ev_valid, core_stall); end
    endtask

    task automatic test_noncontig;
        do_reset();
        bus.commit_valid = 2'b00;
        set_slot(1, 64'h8000_1000, 32'h0000_0013, 1'b1, 5'd7, 64'habc);
        bus.commit_valid[0] = 1'b0;
        tick();
        clear_core();
        n_cmp++; if (protocol_err !== 1'b1 || count !== 4'd1) begin n_err++; $display("FAIL nc_flag: got perr=%b count=%0d expected 1 1", protocol_err, count); end
        n_cmp++; if (bus.ev_pc !== 64'h8000_1000 || bus.ev_wen !== 1'b1 || bus.ev_waddr !== 5'd7 || bus.ev_wdata !== 64'habc) begin n_err++; $display("FAIL nc_fields: got pc=%h wen=%b wa=%0d wd=%h expected 80001000 1 7 abc", bus.ev_pc, bus.ev_wen, bus.ev_waddr, bus.ev_wdata); end
    endtask

    task automatic test_finish_drain;
        do_reset();
        set_slot(0, 64'h10, 32'h13, 1'b0, 5'd0, 64'd0);
        set_slot(1, 64'h14, 32'h13, 1'b0, 5'd0, 64'd0);
        tick();
        set_slot(0, 64'h18, 32'h13, 1'b0, 5'd0, 64'd0);
        set_slot(1, 64'h1c, 32'h13, 1'b0, 5'd0, 64'd0);
        tick();
        clear_core();
        n_cmp++; if (count !== 4'd4 || core_stall !== 1'b0) begin n_err++; $display("FAIL fin_fill: got count=%0d stall=%b expected 4 0", count, core_stall); end
        finish_req = 1'b1;
        tick();
        finish_req = 1'b0;
        n_cmp++; if (core_stall !== 1'b1 || count !== 4'd4 || bus.ev_valid !== 1'b1 || done !== 1'b0) begin n_err++; $display("FAIL fin_enter: got stall=%b count=%0d v=%b done=%b expected 1 4 1 0", core_stall, count, bus.ev_valid, done); end
        bus.ev_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if (bus.ev_pc !== 64'(16 + 4 * i) || done !== 1'b0) begin n_err++; $display("FAIL fin_ev_%0d: got pc=%h done=%b expected pc=%h done=0", i, bus.ev_pc, done, 64'(16 + 4 * i)); end
            tick();
        end
        n_cmp++; if (count !== 4'd0 || bus.ev_valid !== 1'b0 || done !== 1'b0) begin n_err++; $display("FAIL fin_empty: got count=%0d v=%b done=%b expected 0 0 0", count, bus.ev_valid, done); end
        tick();
        n_cmp++; if (done !== 1'b1 || core_stall !== 1'b1 || bus.ev_valid !== 1'b0) begin n_err++; $display("FAIL fin_done: got done=%b stall=%b v=%b expected 1 1 0", done, core_stall, bus.ev_valid); end
        chk_fail = 1'b1;
        tick();
        chk_fail = 1'b0;
        n_cmp++; if (done !== 1'b1 || fail !== 1'b0) begin n_err++; $display("FAIL fin_ignore_chk: got done=%b fail=%b expected 1 0", done, fail); end
    endtask

    task automatic test_fail_priority;
        do_reset();
        set_slot(0, 64'h40, 32'h13, 1'b0, 5'd0, 64'd0);
        tick();
        clear_core();
        set_slot(0, 64'h44, 32'h13, 1'b0, 5'd0, 64'd0);
        set_slot(1, 64'h48, 32'h13, 1'b0, 5'd0, 64'd0);
        tick();
        clear_core();
        n_cmp++; if (count !== 4'd3) begin n_err++; $display("FAIL pri_fill: got count=%0d expected 3", count); end
        chk_fail   = 1'b1;
        finish_req = 1'b1;
        tick();
        chk_fail   = 1'b0;
        finish_req = 1'b0;
        n_cmp++; if (fail !== 1'b1 || bus.ev_valid !== 1'b0 || count !== 4'd3 || done !== 1'b0 || core_stall !== 1'b1) begin n_err++; $display("FAIL pri_halt: got fail=%b v=%b count=%0d done=%b stall=%b expected 1 0 3 0 1", fail, bus.ev_valid, count, done, core_stall); end
        bus.ev_ready = 1'b1;
        set_slot(0, 64'h4c, 32'h13, 1'b0, 5'd0, 64'd0);
        tick();
        clear_core();
        tick();
        n_cmp++; if (count !== 4'd3 || fail !== 1'b1 || done !== 1'b0) begin n_err++; $display("FAIL pri_frozen: got count=%0d fail=%b done=%b expected 3 1 0", count, fail, done); end
    endtask

    task automatic test_mid_reset;
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        n_cmp++; if (fail !== 1'b0 || count !== 4'd0 || bus.ev_valid !== 1'b0 || core_stall !== 1'b0 || bus.ev_pc !== 64'd0) begin n_err++; $display("FAIL mid_reset: got fail=%b count=%0d v=%b stall=%b pc=%h expected 0 0 0 0 0", fail, count, bus.ev_valid, core_stall, bus.ev_pc); end
    endtask

    initial begin
        reset_n = 1'b0;
        clear_inputs();
        test_reset();
        test_dual_commit_trap();
        test_backpressure();
        test_noncontig();
        test_finish_drain();
        test_fail_priority();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/cosim_commit_sched.md
# cosim_commit_sched

Commit-event scheduler between the core's retirement ports and the cosim checker. It captures up to COMMITS retirements plus one trap per cycle into a single ordered FIFO. It then serializes them one event per cycle to the checker over a valid/ready port, and throttles the core when the queue nears full. On a checker mismatch or a tohost finish request it sequences halt or drain.

## Interface
- COMMITS, 2: retirement slots per cycle
- DEPTH, 8: FIFO entries; power of 2, at least COMMITS+1
- XLEN, 64: PC/data width
- clock  in  1  sole clock; all state updates on rising edge
- reset_n  in  1  synchronous, active-low reset
- commit_valid  in  COMMITS  per-slot retirement strobe
- commit_pc  in  COMMITS*XLEN  slot i at bits [i*XLEN +: XLEN]
- commit_insn  in  COMMITS*32  instruction word per slot
- commit_wen  in  COMMITS  slot writes a register
- commit_waddr  in  COMMITS*5  destination register
- commit_wdata  in  COMMITS*XLEN  writeback data
- trap_valid  in  1  trap taken this cycle
- trap_cause  in  XLEN  trap cause
- finish_req  in  1  tohost bit 0 set
- ev_valid  out  1  event available
- ev_ready  in  1  checker accepts event
- ev_is_trap  out  1  1 = trap event, 0 = commit event
- ev_pc, ev_insn, ev_wen, ev_waddr, ev_wdata  out  XLEN/32/1/5/XLEN  commit fields; zero for traps
- ev_cause  out  XLEN  trap cause; zero for commits
- chk_fail  in  1  checker mismatch pulse
- core_stall  out  1  core must not retire next cycle
- done  out  1  drain complete
- fail, overflow, protocol_err  out  1 each  sticky error flags
- count  out  $clog2(DEPTH)+1  current occupancy

## Operation
- States: RUN, DRAIN, HALT, DONE. Reset enters RUN.
- **Enqueue** (RUN and DRAIN only):
  - Valid slots are written in slot order 0..COMMITS-1.
  - A trap in the same cycle is written after that cycle's commits, because the trap belongs to the next instruction.
  - Push count per cycle = popcount(commit_valid) + trap_valid.
- **Contiguity rule:** slot i valid with slot i-1 invalid sets protocol_err. The valid slots are still enqueued in ascending order.
- **Overflow:** pushes exceeding free space (DEPTH − count + pop_this_cycle) are dropped and set overflow. The dropped ones are the highest-order ones, so the trap is dropped first.
- **core_stall** = (count > DEPTH − (COMMITS+1)) OR state ≠ RUN. It is computed from registered count only.
- **Dequeue:** a pop occurs when ev_valid && ev_ready. ev_valid = (count ≠ 0) && state ∈ {RUN, DRAIN}.
- **Transitions:**
  - RUN→HALT on chk_fail. chk_fail has priority over finish_req in the same cycle.
  - RUN→DRAIN on finish_req.
  - DRAIN→HALT on chk_fail.
  - DRAIN→DONE when count = 0 and no push or pop is pending.
  - HALT and DONE are terminal until reset.
- **HALT:** sets fail. ev_valid=0. FIFO contents are frozen and count holds.
- **DONE:** done=1, ev_valid=0.
- chk_fail in DONE is ignored.
- Pushes presented during DRAIN are accepted; they violate core_stall, and space permitting they are still checked.
- Pointers wrap modulo DEPTH. count is the exact occupancy, 0..DEPTH.

## Timing
- Reset values: ev_valid=0, all ev_* fields 0, core_stall=0, done=0, fail=0, overflow=0, protocol_err=0, count=0.
- **Latency:** an event pushed in cycle t is presented on ev_* in cycle t+1 at the earliest (empty FIFO).
- **Throughput:** 1 event/cycle out.
- ev_* are driven from the FIFO head and held stable while ev_valid && !ready.
- Simultaneous push and pop: count += pushes − pop within the same edge.
- Full with pop pending: a push may use the slot freed by the pop.
- finish_req / chk_fail are sampled at the edge. The state change is visible one cycle later, together with core_stall=1.
- reset_n low mid-operation: everything returns to reset values at the next edge, and queued events are discarded.

## Test plan
- **Reset:** hold reset_n=0 for 3 cycles with commit_valid=2'b11 → count=0, ev_valid=0, all flags 0.
- **Dual commit + trap, ev_ready=1:** pc0=0x80000000, pc1=0x80000004, trap_valid=1 with cause=0x2 in the same cycle → ev_valid from t+1 for 3 cycles, emitting pc 0x80000000, then 0x80000004, then trap cause 0x2.
- **Backpressure:** ev_ready=0 with one commit/cycle → core_stall=1 once count=6. Forcing 2 more commits at count=7 → one accepted, one dropped, overflow=1, count=8.
- **Non-contiguous slots:** commit_valid=2'b10 → protocol_err=1 and one event enqueued with slot-1 fields.
- **Finish drain:** 4 queued events, then finish_req pulse with ev_ready=1 → core_stall=1, 4 events emitted, done=1 in the cycle after count reaches 0.
- **Failure priority:** chk_fail and finish_req together with 3 queued events → HALT, fail=1, ev_valid=0, count stays 3, done stays 0.
